mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_mem_responder.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Behavioural memory slave for a small CPU. It has a single 2^ADDR_W x 32-bit
// word array shared by two independent channels:
//
//   * Instruction channel: fetch-only. A request is accepted in I_IDLE. The
//     addressed word is captured at the accepting edge. Inst_Valid rises
//     INST_LAT cycles later and holds until the initiator takes the word.
//   * Data channel: byte-enabled writes complete in one accepting cycle and
//     produce no response. Reads follow the same capture/latency/handshake
//     pattern as fetches, using DATA_LAT.
//
// Both channels capture the addressed word at the accepting edge. A data write
// on the same edge is not yet visible, so a same-edge read returns the old
// word. Address bits [1:0] are ignored. Bits above ADDR_W+1 are also ignored,
// so addresses wrap. ADDR_W must be no more than 29.
//
// Ports
//   clk              sole clock, rising edge
//   rst              asynchronous active-high reset
//   PC               fetch byte address
//   Inst_Req_Valid   fetch request valid
//   Inst_Req_Ready   fetch request accepted (high only when fetch side idle)
//   Instruction      fetched word, stable while Inst_Valid
//   Inst_Valid       Instruction valid
//   Inst_Ready       initiator takes Instruction
//   Address          data byte address
//   MemWrite         data write request (takes priority over MemRead)
//   Write_data       write data
//   Write_strb       byte-lane enables for Write_data
//   MemRead          data read request
//   Mem_Req_Ready    data request accepted (high only when data side idle)
//   Read_data        read word, stable while Read_data_Valid
//   Read_data_Valid  Read_data valid
//   Read_data_Ready  initiator takes Read_data
// -----------------------------------------------------------------------------
module mem_responder #(
   parameter int ADDR_W   = 12,
   parameter int INST_LAT = 2,
   parameter int DATA_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,

   // instruction channel
   input  logic [31:0] PC,
   input  logic        Inst_Req_Valid,
   output logic        Inst_Req_Ready,
   output logic [31:0] Instruction,
   output logic        Inst_Valid,
   input  logic        Inst_Ready,

   // data channel
   input  logic [31:0] Address,
   input  logic        MemWrite,
   input  logic [31:0] Write_data,
   input  logic [3:0]  Write_strb,
   input  logic        MemRead,
   output logic        Mem_Req_Ready,
   output logic [31:0] Read_data,
   output logic        Read_data_Valid,
   input  logic        Read_data_Ready
);

   localparam int DEPTH = 1 << ADDR_W;

   // The wait counter is loaded with LAT-1. The FSM then leaves the wait
   // state on the edge after the counter reaches zero. This places valid
   // exactly LAT edges after the accepting edge.
   localparam logic [3:0] I_LOAD = 4'(INST_LAT - 1);
   localparam logic [3:0] D_LOAD = 4'(DATA_LAT - 1);

   typedef enum logic [1:0] {
      I_IDLE = 2'd0,
      I_WAIT = 2'd1,
      I_RESP = 2'd2
   } i_state_e;

   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_WAIT = 2'd1,
      D_RESP = 2'd2
   } d_state_e;

   // ------------------------------------------------------------------
   // Storage and address decode
   // ------------------------------------------------------------------
   logic [31:0]       mem_q [DEPTH];

   logic [ADDR_W-1:0] pc_idx;
   logic [ADDR_W-1:0] addr_idx;

   assign pc_idx   = PC[ADDR_W+1:2];
   assign addr_idx = Address[ADDR_W+1:2];

   // ------------------------------------------------------------------
   // Handshake events
   // ------------------------------------------------------------------
   logic inst_accept;
   logic wr_accept;
   logic rd_accept;

   assign inst_accept = Inst_Req_Valid & Inst_Req_Ready;

   // A request that asserts both MemWrite and MemRead is treated as a
   // write only.
   assign wr_accept = MemWrite & Mem_Req_Ready;
   assign rd_accept = MemRead & ~MemWrite & Mem_Req_Ready;

   // ------------------------------------------------------------------
   // Instruction FSM: state register
   // ------------------------------------------------------------------
   i_state_e   i_state_q;
   i_state_e   i_state_d;
   logic [3:0] i_cnt_q;
   logic [3:0] i_cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_state_q <= I_IDLE;
         i_cnt_q   <= 4'd0;
      end else begin
         i_state_q <= i_state_d;
         i_cnt_q   <= i_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Instruction FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      i_state_d = i_state_q;
      i_cnt_d   = i_cnt_q;
      case (i_state_q)
         I_IDLE: begin
            if (inst_accept) begin
               i_state_d = I_WAIT;
               i_cnt_d   = I_LOAD;
            end
         end
         I_WAIT: begin
            if (i_cnt_q == 4'd0) begin
               i_state_d = I_RESP;
            end else begin
               i_cnt_d = i_cnt_q - 4'd1;
            end
         end
         I_RESP: begin
            // Inst_Valid is high throughout this state, so Inst_Ready alone
            // completes the handshake.
            if (Inst_Ready) begin
               i_state_d = I_IDLE;
            end
         end
         default: begin
            i_state_d = I_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Instruction FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      Inst_Req_Ready = 1'b0;
      Inst_Valid     = 1'b0;
      case (i_state_q)
         // Ready is masked by rst, so no request can be accepted while
         // reset is held. Ready returns in the first cycle after release.
         I_IDLE:  Inst_Req_Ready = ~rst;
         I_RESP:  Inst_Valid     = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Data FSM: state register
   // ------------------------------------------------------------------
   d_state_e   d_state_q;
   d_state_e   d_state_d;
   logic [3:0] d_cnt_q;
   logic [3:0] d_cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_state_q <= D_IDLE;
         d_cnt_q   <= 4'd0;
      end else begin
         d_state_q <= d_state_d;
         d_cnt_q   <= d_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Data FSM: next state (writes never leave D_IDLE)
   // ------------------------------------------------------------------
   always_comb begin
      d_state_d = d_state_q;
      d_cnt_d   = d_cnt_q;
      case (d_state_q)
         D_IDLE: begin
            if (rd_accept) begin
               d_state_d = D_WAIT;
               d_cnt_d   = D_LOAD;
            end
         end
         D_WAIT: begin
            if (d_cnt_q == 4'd0) begin
               d_state_d = D_RESP;
            end else begin
               d_cnt_d = d_cnt_q - 4'd1;
            end
         end
         D_RESP: begin
            if (Read_data_Ready) begin
               d_state_d = D_IDLE;
            end
         end
         default: begin
            d_state_d = D_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Data FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      Mem_Req_Ready   = 1'b0;
      Read_data_Valid = 1'b0;
      case (d_state_q)
         D_IDLE:  Mem_Req_Ready   = ~rst;
         D_RESP:  Read_data_Valid = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Memory array: byte-lane writes, no reset.
   // wr_accept is already masked by rst through Mem_Req_Ready, so an
   // aborted transaction cannot write.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         for (int i = 0; i < 4; i++) begin
            if (Write_strb[i]) begin
               mem_q[addr_idx][i*8 +: 8] <= Write_data[i*8 +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Response capture registers.
   // These are sampled at the accepting edge, which gives same-edge writes
   // old-data semantics. They are not written again until the next accept,
   // so each response is stable while its valid is held.
   // ------------------------------------------------------------------
   logic [31:0] inst_word_q;
   logic [31:0] rd_word_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_word_q <= 32'd0;
      end else if (inst_accept) begin
         inst_word_q <= mem_q[pc_idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_word_q <= 32'd0;
      end else if (rd_accept) begin
         rd_word_q <= mem_q[addr_idx];
      end
   end

   assign Instruction = inst_word_q;
   assign Read_data   = rd_word_q;

   // ------------------------------------------------------------------
   // Acceptance counters (observation only, wrap naturally at 2^32)
   // ------------------------------------------------------------------
   logic [31:0] inst_acc_cnt;
   logic [31:0] rd_acc_cnt;
   logic [31:0] wr_acc_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_acc_cnt <= 32'd0;
         rd_acc_cnt   <= 32'd0;
         wr_acc_cnt   <= 32'd0;
      end else begin
         if (inst_accept) inst_acc_cnt <= inst_acc_cnt + 32'd1;
         if (rd_accept)   rd_acc_cnt   <= rd_acc_cnt + 32'd1;
         if (wr_accept)   wr_acc_cnt   <= wr_acc_cnt + 32'd1;
      end
   end

   // Address bits outside the word index are intentionally ignored. The
   // counters have no port. Both are gathered here so they are not flagged
   // as dangling.
   logic unused_bits;
   assign unused_bits = ^{PC[31:ADDR_W+2], PC[1:0],
                          Address[31:ADDR_W+2], Address[1:0],
                          inst_acc_cnt, rd_acc_cnt, wr_acc_cnt};

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   localparam int ADDR_W   = 12;
   localparam int INST_LAT = 2;
   localparam int DATA_LAT = 2;
   localparam int DEPTH    = 1 << ADDR_W;
   localparam int WIN      = 64;   // words initialised and used by random traffic

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] PC = '0;
   logic        Inst_Req_Valid = 1'b0;
   logic        Inst_Req_Ready;
   logic [31:0] Instruction;
   logic        Inst_Valid;
   logic        Inst_Ready = 1'b1;
   logic [31:0] Address = '0;
   logic        MemWrite = 1'b0;
   logic [31:0] Write_data = '0;
   logic [3:0]  Write_strb = '0;
   logic        MemRead = 1'b0;
   logic        Mem_Req_Ready;
   logic [31:0] Read_data;
   logic        Read_data_Valid;
   logic        Read_data_Ready = 1'b1;

   mem_responder #(
      .ADDR_W   (ADDR_W),
      .INST_LAT (INST_LAT),
      .DATA_LAT (DATA_LAT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .PC              (PC),
      .Inst_Req_Valid  (Inst_Req_Valid),
      .Inst_Req_Ready  (Inst_Req_Ready),
      .Instruction     (Instruction),
      .Inst_Valid      (Inst_Valid),
      .Inst_Ready      (Inst_Ready),
      .Address         (Address),
      .MemWrite        (MemWrite),
      .Write_data      (Write_data),
      .Write_strb      (Write_strb),
      .MemRead         (MemRead),
      .Mem_Req_Ready   (Mem_Req_Ready),
      .Read_data       (Read_data),
      .Read_data_Valid (Read_data_Valid),
      .Read_data_Ready (Read_data_Ready)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------
   // Bookkeeping and reference model
   // ---------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] ref_mem [DEPTH];
   logic [31:0] inst_exp_q [$];
   logic [31:0] rd_exp_q [$];

   int          edge_n = 0;        // rising edges seen by the stimulus
   bit          ibusy = 0;
   bit          dbusy = 0;
   int          ivalid_from = 0;   // edge after which the response is visible
   int          dvalid_from = 0;
   int unsigned m_inst_cnt = 0;
   int unsigned m_rd_cnt = 0;
   int unsigned m_wr_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   task automatic model_reset();
      ibusy = 0;
      dbusy = 0;
      inst_exp_q.delete();
      rd_exp_q.delete();
      m_inst_cnt = 0;
      m_rd_cnt   = 0;
      m_wr_cnt   = 0;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   // Check visible handshake signals, then model the coming edge with the
   // inputs the caller has set, then advance one cycle.
   task automatic tick();
      bit i_idle;
      bit d_idle;
      int w;
      i_idle = !ibusy;
      d_idle = !dbusy;
      check("inst_req_ready", 32'(Inst_Req_Ready), 32'(i_idle));
      check("mem_req_ready",  32'(Mem_Req_Ready),  32'(d_idle));
      check("inst_valid",     32'(Inst_Valid),     32'(ibusy && edge_n >= ivalid_from));
      check("read_valid",     32'(Read_data_Valid), 32'(dbusy && edge_n >= dvalid_from));

      // Reads see memory before any same-edge write.
      if (i_idle && Inst_Req_Valid) begin
         inst_exp_q.push_back(ref_mem[widx(PC)]);
         ibusy = 1;
         ivalid_from = edge_n + 1 + INST_LAT;
         m_inst_cnt++;
      end else if (ibusy && edge_n >= ivalid_from && Inst_Ready) begin
         ibusy = 0;
      end

      if (d_idle && MemRead && !MemWrite) begin
         rd_exp_q.push_back(ref_mem[widx(Address)]);
         dbusy = 1;
         dvalid_from = edge_n + 1 + DATA_LAT;
         m_rd_cnt++;
      end else if (dbusy && edge_n >= dvalid_from && Read_data_Ready) begin
         dbusy = 0;
      end

      if (d_idle && MemWrite) begin
         w = widx(Address);
         for (int i = 0; i < 4; i++)
            if (Write_strb[i]) ref_mem[w][i*8 +: 8] = Write_data[i*8 +: 8];
         m_wr_cnt++;
      end
      adv();
   endtask

   task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      Address = a; Write_data = d; Write_strb = s; MemWrite = 1'b1;
      tick();
      MemWrite = 1'b0;
      $display("write addr=%h data=%h strb=%b", a, d, s);
   endtask

   // Issue a fetch, measure its latency, check the word against a constant.
   task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, input string name);
      int k;
      Inst_Ready = 1'b1;
      PC = pc; Inst_Req_Valid = 1'b1;
      tick();
      Inst_Req_Valid = 1'b0;
      k = 0;
      while (!Inst_Valid && k < 40) begin
         tick();
         k++;
      end
      check({name, "_latency"}, 32'(k), 32'(INST_LAT));
      check(name, Instruction, exp);
      $display("fetch pc=%h instruction=%h latency=%0d", pc, Instruction, k);
      tick();   // handshake edge
   endtask

   task automatic read_word(input logic [31:0] a, input logic [31:0] exp, input string name);
      int k;
      Read_data_Ready = 1'b1;
      Address = a; MemRead = 1'b1;
      tick();
      MemRead = 1'b0;
      k = 0;
      while (!Read_data_Valid && k < 40) begin
         tick();
         k++;
      end
      check({name, "_latency"}, 32'(k), 32'(DATA_LAT));
      check(name, Read_data, exp);
      $display("read addr=%h data=%h latency=%0d", a, Read_data, k);
      tick();
   endtask

   task automatic drain();
      int k;
      Inst_Req_Valid = 0; MemRead = 0; MemWrite = 0;
      Inst_Ready = 1; Read_data_Ready = 1;
      k = 0;
      while ((ibusy || dbusy) && k < 60) begin
         tick();
         k++;
      end
      check("drain_idle", 32'(ibusy || dbusy), 32'd0);
      tick();
      tick();
      check("inst_queue_empty", 32'(inst_exp_q.size()), 32'd0);
      check("rd_queue_empty",   32'(rd_exp_q.size()),   32'd0);
   endtask

   // ---------------------------------------------------------------
   // Monitor: pops the scoreboard on every completed response and checks
   // that held responses do not change or drop.
   // ---------------------------------------------------------------
   logic        prev_iv = 0, prev_ir = 0, prev_dv = 0, prev_dr = 0;
   logic [31:0] prev_inst = '0, prev_rd = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_iv <= 1'b0;
         prev_dv <= 1'b0;
      end else begin
         if (prev_iv && !prev_ir) begin
            check("inst_valid_held", 32'(Inst_Valid), 32'd1);
            check("inst_stable", Instruction, prev_inst);
         end
         if (prev_dv && !prev_dr) begin
            check("read_valid_held", 32'(Read_data_Valid), 32'd1);
            check("read_stable", Read_data, prev_rd);
         end
         if (Inst_Valid && Inst_Ready) begin
            if (inst_exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL inst_unexpected: got response %h expected none", Instruction);
            end else begin
               check("instruction", Instruction, inst_exp_q.pop_front());
            end
         end
         if (Read_data_Valid && Read_data_Ready) begin
            if (rd_exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL read_unexpected: got response %h expected none", Read_data);
            end else begin
               check("read_data", Read_data, rd_exp_q.pop_front());
            end
         end
         prev_iv   <= Inst_Valid;
         prev_ir   <= Inst_Ready;
         prev_inst <= Instruction;
         prev_dv   <= Read_data_Valid;
         prev_dr   <= Read_data_Ready;
         prev_rd   <= Read_data;
      end
   end

   // ---------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------
   initial begin
      logic [31:0] held;
      int          k;

      // Reset state
      rst = 1'b1;
      adv(); adv(); adv();
      check("rst_inst_req_ready", 32'(Inst_Req_Ready), 32'd0);
      check("rst_mem_req_ready",  32'(Mem_Req_Ready),  32'd0);
      check("rst_inst_valid",     32'(Inst_Valid),     32'd0);
      check("rst_read_valid",     32'(Read_data_Valid), 32'd0);
      check("rst_instruction",    Instruction, 32'd0);
      check("rst_read_data",      Read_data,   32'd0);
      rst = 1'b0;
      #1;
      check("rel_inst_req_ready", 32'(Inst_Req_Ready), 32'd1);
      check("rel_mem_req_ready",  32'(Mem_Req_Ready),  32'd1);
      check("rel_inst_cnt", dut.inst_acc_cnt, 32'd0);
      check("rel_rd_cnt",   dut.rd_acc_cnt,   32'd0);
      check("rel_wr_cnt",   dut.wr_acc_cnt,   32'd0);
      $display("reset released");

      // Initialise the working window to zero.
      for (int i = 0; i < WIN; i++) begin
         Address = 32'(i * 4); Write_data = '0; Write_strb = 4'hF; MemWrite = 1'b1;
         tick();
      end
      MemWrite = 1'b0;

      // Preloaded word fetched at PC 0x10
      write_word(32'h10, 32'h00500093, 4'hF);
      fetch(32'h10, 32'h00500093, "fetch_preload");

      // Byte-lane merge
      write_word(32'h20, 32'hAABBCCDD, 4'b1111);
      write_word(32'h20, 32'h00001100, 4'b0010);
      read_word(32'h20, 32'hAABB11DD, "read_merged");

      // Back-pressure: response held 5 cycles, new requests ignored
      Read_data_Ready = 1'b0;
      Address = 32'h20; MemRead = 1'b1;
      tick();
      MemRead = 1'b0;
      k = 0;
      while (!Read_data_Valid && k < 40) begin
         tick();
         k++;
      end
      held = Read_data;
      for (int i = 0; i < 5; i++) begin
         Address = 32'h0; MemRead = 1'b1;
         tick();
         check("hold_valid", 32'(Read_data_Valid), 32'd1);
         check("hold_data", Read_data, 32'hAABB11DD);
         check("hold_data_const", Read_data, held);
         check("hold_mem_req_ready", 32'(Mem_Req_Ready), 32'd0);
      end
      MemRead = 1'b0;
      Read_data_Ready = 1'b1;
      tick();
      $display("backpressure read data=%h released", held);

      // Same-edge fetch and write of one word: fetch sees the old value
      Inst_Ready = 1'b1;
      PC = 32'h40; Inst_Req_Valid = 1'b1;
      Address = 32'h40; Write_data = 32'h12345678; Write_strb = 4'hF; MemWrite = 1'b1;
      tick();
      Inst_Req_Valid = 1'b0; MemWrite = 1'b0;
      k = 0;
      while (!Inst_Valid && k < 40) begin
         tick();
         k++;
      end
      check("same_edge_old", Instruction, 32'h0);
      $display("same-edge fetch pc=40 instruction=%h", Instruction);
      tick();
      fetch(32'h40, 32'h12345678, "fetch_after_write");

      // Aliasing, and read+write treated as write only
      Address = 32'h4000; Write_data = 32'hCAFEF00D; Write_strb = 4'hF;
      MemWrite = 1'b1; MemRead = 1'b1;
      tick();
      MemWrite = 1'b0; MemRead = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rw_no_response", 32'(Read_data_Valid), 32'd0);
      end
      $display("write+read addr=4000 data=cafef00d, no response");
      read_word(32'h0, 32'hCAFEF00D, "alias_word0");

      // Randomised traffic against the reference model
      for (int c = 0; c < 1500; c++) begin
         logic [31:0] rnd;
         rnd = $urandom;
         PC = ($urandom & 32'hFFFFC003) | (32'($urandom_range(0, WIN - 1)) << 2);
         Inst_Req_Valid = rnd[0];
         Inst_Ready = (rnd[2:1] != 2'b00);
         Address = ($urandom & 32'hFFFFC003) | (32'($urandom_range(0, WIN - 1)) << 2);
         MemWrite = (rnd[4:3] == 2'b00);
         MemRead = rnd[5];
         Write_data = $urandom;
         Write_strb = rnd[9:6];
         Read_data_Ready = (rnd[11:10] != 2'b00);
         tick();
         if (c % 100 == 0)
            $display("random cycle %0d: fetches=%0d reads=%0d writes=%0d", c, m_inst_cnt, m_rd_cnt, m_wr_cnt);
      end
      drain();
      check("inst_acc_cnt", dut.inst_acc_cnt, m_inst_cnt);
      check("rd_acc_cnt",   dut.rd_acc_cnt,   m_rd_cnt);
      check("wr_acc_cnt",   dut.wr_acc_cnt,   m_wr_cnt);
      $display("counters inst=%0d rd=%0d wr=%0d", dut.inst_acc_cnt, dut.rd_acc_cnt, dut.wr_acc_cnt);

      // Reset during an outstanding fetch and read aborts both
      PC = 32'h10; Inst_Req_Valid = 1'b1;
      Address = 32'h20; MemRead = 1'b1;
      tick();
      Inst_Req_Valid = 1'b0; MemRead = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      check("abort_inst_valid", 32'(Inst_Valid), 32'd0);
      check("abort_inst_req_ready", 32'(Inst_Req_Ready), 32'd0);
      check("abort_mem_req_ready", 32'(Mem_Req_Ready), 32'd0);
      check("abort_instruction", Instruction, 32'd0);
      check("abort_read_data", Read_data, 32'd0);
      for (int i = 0; i < 4; i++) begin
         adv();
         check("abort_inst_valid_low", 32'(Inst_Valid), 32'd0);
         check("abort_read_valid_low", 32'(Read_data_Valid), 32'd0);
      end
      rst = 1'b0;
      #1;
      check("post_abort_inst_req_ready", 32'(Inst_Req_Ready), 32'd1);
      check("post_abort_inst_cnt", dut.inst_acc_cnt, 32'd0);
      check("post_abort_rd_cnt",   dut.rd_acc_cnt,   32'd0);
      check("post_abort_wr_cnt",   dut.wr_acc_cnt,   32'd0);
      $display("reset during fetch: aborted");
      for (int i = 0; i < 6; i++) tick();
      fetch(32'h10, ref_mem[4], "fetch_after_abort");
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time limit
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
